leaf_out_port_bridge: RTL

Parametrised per-channel buffer between a user kernel's HLS output streams (ap_vld/ap_ack) and the leaf interface's user-side input ports (vld_user2interface/ack_interface2user). Each of NUM_OUT_PORTS channels gets an independent FIFO. This decouples kernel stalls from BFT backpressure and adds per-channel flush and stall detection. It sits inside a leaf, in the clk_user domain, replacing direct kernel-to-interface wiring for multi-output kernels.

---
 rtl/leaf_out_port_bridge.sv | 106 ++++++++++
 1 files changed

// File: rtl/leaf_out_port_bridge.sv
// Per-channel FIFO bridge from kernel ap_vld/ap_ack output streams to leaf interface user-side ports.
// Optional per-channel statistics outputs are enabled by defining LEAF_BRIDGE_STATS_EN.
module leaf_out_port_bridge #(
  parameter int PAYLOAD_BITS    = 32,
  parameter int NUM_OUT_PORTS   = 2,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int STALL_LIMIT     = 255
) (
  input  logic                                  clk_user,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] user_data,
  input  logic [NUM_OUT_PORTS-1:0]              user_vld,
  output logic [NUM_OUT_PORTS-1:0]              user_ack,
  output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_data,
  output logic [NUM_OUT_PORTS-1:0]              if_vld,
  input  logic [NUM_OUT_PORTS-1:0]              if_ack,
  input  logic [NUM_OUT_PORTS-1:0]              flush,
  output logic [NUM_OUT_PORTS-1:0]              stall_flag,
  input  logic [NUM_OUT_PORTS-1:0]              stall_clr
`ifdef LEAF_BRIDGE_STATS_EN
  ,
  output logic [NUM_OUT_PORTS*32-1:0]                  stat_words,
  output logic [NUM_OUT_PORTS*(FIFO_DEPTH_BITS+1)-1:0] stat_hwm
`endif
);

  localparam int PW    = FIFO_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam logic [15:0] STALL_SET_AT = 16'(STALL_LIMIT - 1);
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

  // Handshake: a word moves on a rising edge where vld=1 and ack=1 on the same side;
  // ack never depends on vld of that side, and vld is driven from registered state only.
  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_ch
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    blocked;
    logic [15:0]             stall_cnt;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign user_ack[i] = !full && !flush[i];
    assign push    = user_vld[i] && user_ack[i];
    assign if_vld[i] = !empty;
    assign if_data[i*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr[FIFO_DEPTH_BITS-1:0]];
    assign pop     = !empty && if_ack[i] && !flush[i];
    assign blocked = !empty && !if_ack[i];

    // Storage is intentionally left unreset; if_data is meaningless while if_vld=0.
    always_ff @(posedge clk_user) begin
      if (push) mem[wr_ptr[FIFO_DEPTH_BITS-1:0]] <= user_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (flush[i]) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end

    // Flag sets only on the cycle the count reaches the limit, so a clear sticks while blocked.
    always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
        stall_cnt     <= '0;
        stall_flag[i] <= 1'b0;
      end else begin
        if (flush[i] || pop || empty) stall_cnt <= '0;
        else if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;

        if (blocked && !flush[i] && stall_cnt == STALL_SET_AT) stall_flag[i] <= 1'b1;
        else if (stall_clr[i]) stall_flag[i] <= 1'b0;
      end
    end

`ifdef LEAF_BRIDGE_STATS_EN
    logic [31:0]   words_cnt;
    logic [PW-1:0] hwm;
    logic [PW-1:0] occ;

    assign occ = wr_ptr - rd_ptr;
    assign stat_words[i*32 +: 32] = words_cnt;
    assign stat_hwm[i*PW +: PW]   = hwm;

    always_ff @(posedge clk_user or negedge reset) begin
      if (!reset) begin
        words_cnt <= '0;
        hwm       <= '0;
      end else begin
        if (pop) words_cnt <= words_cnt + 32'd1;
        if (occ > hwm) hwm <= occ;
      end
    end
`endif
  end

endmodule
